spi_instruction_fetch: RTL and testbench

- Producer end of the decoder's 32-bit instruction input.
- Fetches one instruction word from an external SPI NOR flash using the READ command (0x03, 24-bit address, mode 0).
- Assembles the four little-endian bytes and holds the word for the core under a valid/accept handshake.
- Sits between the program counter logic and instruction_decoder.

---
 rtl/spi_instruction_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_spi_instruction_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_instruction_fetch.sv
// -----------------------------------------------------------------------------
// spi_instruction_fetch
//
// Fetches one 32-bit instruction word from an external SPI NOR flash with the
// plain READ command (SPI mode 0). The address is sent MSB first, and then
// 32 data bits are clocked in. The four received bytes are little-endian:
// the first byte on the wire is instruction[7:0]. The word is held for the
// core under a valid/accept handshake. A misaligned address is not sent to
// the flash. It is answered with an error result instead.
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   fetch_request       start a fetch (only looked at while fetch_ready=1)
//   fetch_address[31:0] byte address, captured when the request is accepted
//   fetch_ready         idle and able to take a request
//   instruction[31:0]   fetched word (zero on error), stable while valid
//   instruction_valid   result available
//   instruction_accept  consumer takes the result this cycle
//   fetch_error         qualifies instruction_valid: misaligned address
//   spi_cs_n            flash chip select, active-low
//   spi_sck             serial clock, idles low
//   spi_mosi            serial data to the flash
//   spi_miso            serial data from the flash
// -----------------------------------------------------------------------------
module spi_instruction_fetch #(
    parameter int          CLOCK_DIVIDER = 2,      // clk cycles per SCK half-period
    parameter logic [7:0]  READ_COMMAND  = 8'h03,
    parameter int          ADDRESS_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic        fetch_ready,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    input  logic        instruction_accept,
    output logic        fetch_error,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Command plus address bits shifted out, then 32 data bits shifted in.
    localparam int TX_BITS    = 8 + ADDRESS_WIDTH;
    localparam int TOTAL_BITS = TX_BITS + 32;
    localparam int CNT_W      = $clog2(TOTAL_BITS);
    localparam int DIV_W      = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int DES_W      = $clog2(2 * CLOCK_DIVIDER);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DES_W-1:0] DES_LAST = DES_W'(2 * CLOCK_DIVIDER - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);
    localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(8);
    localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(TX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        DESELECT
    } state_t;

    state_t             state_reg;
    logic [DIV_W-1:0]   div_cnt_reg;     // position inside one SCK half-period
    logic [CNT_W-1:0]   bit_cnt_reg;     // bit index across all phases
    logic [DES_W-1:0]   desel_cnt_reg;   // minimum chip-select-high time
    logic [TX_BITS-1:0] tx_shift_reg;    // command and address, MSB first
    logic [31:0]        rx_shift_reg;    // received bits, first bit ends up at MSB

    logic [CNT_W-1:0]   bit_cnt_next;
    logic [31:0]        rx_word;

    assign bit_cnt_next = bit_cnt_reg + CNT_W'(1);

    // After 32 shifts the first byte received is in rx_shift_reg[31:24].
    // Reverse the byte order so that this byte becomes instruction[7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_swap
            assign rx_word[8*gi +: 8] = rx_shift_reg[8*(3-gi) +: 8];
        end
    endgenerate

    // The address bits above ADDRESS_WIDTH are deliberately not sent.
    generate
        if (ADDRESS_WIDTH < 32) begin : g_upper_addr
            logic unused_upper_address;
            assign unused_upper_address = ^fetch_address[31:ADDRESS_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            div_cnt_reg       <= '0;
            bit_cnt_reg       <= '0;
            desel_cnt_reg     <= '0;
            tx_shift_reg      <= '0;
            rx_shift_reg      <= '0;
            spi_cs_n          <= 1'b1;
            spi_sck           <= 1'b0;
            spi_mosi          <= 1'b0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            fetch_error       <= 1'b0;
            fetch_ready       <= 1'b1;
        end else begin
            // Handshake. A new result is only produced while valid is low,
            // so this never conflicts with the result writes below.
            if (instruction_valid && instruction_accept) begin
                instruction_valid <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (fetch_ready && fetch_request) begin
                        fetch_ready <= 1'b0;
                        if (fetch_address[1:0] != 2'b00) begin
                            // Misaligned address. Answer at once and leave the bus idle.
                            instruction_valid <= 1'b1;
                            fetch_error       <= 1'b1;
                            instruction       <= '0;
                        end else begin
                            tx_shift_reg <= {READ_COMMAND, fetch_address[ADDRESS_WIDTH-1:0]};
                            spi_cs_n     <= 1'b0;
                            spi_sck      <= 1'b0;
                            spi_mosi     <= READ_COMMAND[7];
                            div_cnt_reg  <= '0;
                            state_reg    <= COMMAND;
                        end
                    end else begin
                        // This is ready for the next cycle. An error result that is
                        // still pending blocks it until it is accepted.
                        fetch_ready <= !(instruction_valid && !instruction_accept);
                    end
                end

                COMMAND, ADDRESS, DATA: begin
                    if (div_cnt_reg != DIV_LAST) begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end else begin
                        div_cnt_reg <= '0;
                        if (!spi_sck) begin
                            // Rising SCK edge: the flash has already driven MISO
                            // for at least one half-period.
                            spi_sck <= 1'b1;
                            if (state_reg == DATA) begin
                                rx_shift_reg <= {rx_shift_reg[30:0], spi_miso};
                            end
                        end else begin
                            // End of a bit. SCK falls and MOSI moves to the next bit.
                            spi_sck <= 1'b0;
                            if (bit_cnt_reg == LAST_BIT) begin
                                spi_cs_n          <= 1'b1;
                                spi_mosi          <= 1'b0;
                                instruction       <= rx_word;
                                instruction_valid <= 1'b1;
                                fetch_error       <= 1'b0;
                                desel_cnt_reg     <= '0;
                                state_reg         <= DESELECT;
                            end else begin
                                bit_cnt_reg  <= bit_cnt_next;
                                tx_shift_reg <= tx_shift_reg << 1;
                                if (bit_cnt_next == CMD_END) begin
                                    state_reg <= ADDRESS;
                                end
                                if (bit_cnt_next >= ADDR_END) begin
                                    state_reg <= DATA;
                                    spi_mosi  <= 1'b0;
                                end else begin
                                    spi_mosi  <= tx_shift_reg[TX_BITS-2];
                                end
                            end
                        end
                    end
                end

                DESELECT: begin
                    // Hold chip select high for the minimum time. Then wait
                    // until the consumer has taken the word.
                    if (desel_cnt_reg != DES_LAST) begin
                        desel_cnt_reg <= desel_cnt_reg + DES_W'(1);
                    end else if (!instruction_valid) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                        fetch_ready <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_instruction_fetch
//
// Two fetch units share one behavioural SPI flash. dut0 runs with
// CLOCK_DIVIDER=2 and dut1 runs with CLOCK_DIVIDER=1. Only one unit is
// active at a time. An idle unit drives cs_n=1 and sck=mosi=0, so the buses
// are merged with AND/OR. Expected results are queued when a request is
// issued and compared when instruction_valid rises.
// -----------------------------------------------------------------------------
module tb_spi_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b1;
    logic [1:0]       fetch_request = '0;
    logic [31:0]      fetch_address = '0;
    logic [1:0]       instruction_accept = '0;
    logic [1:0]       fetch_ready, instruction_valid, fetch_error;
    logic [1:0]       spi_cs_n, spi_sck, spi_mosi;
    logic [1:0][31:0] instruction;
    logic             flash_miso = 1'b0;

    spi_instruction_fetch #(.CLOCK_DIVIDER(2), .READ_COMMAND(8'h03), .ADDRESS_WIDTH(24)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .fetch_request(fetch_request[0]), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready[0]), .instruction(instruction[0]),
        .instruction_valid(instruction_valid[0]), .instruction_accept(instruction_accept[0]),
        .fetch_error(fetch_error[0]),
        .spi_cs_n(spi_cs_n[0]), .spi_sck(spi_sck[0]), .spi_mosi(spi_mosi[0]), .spi_miso(flash_miso)
    );

    spi_instruction_fetch #(.CLOCK_DIVIDER(1), .READ_COMMAND(8'h03), .ADDRESS_WIDTH(24)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .fetch_request(fetch_request[1]), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready[1]), .instruction(instruction[1]),
        .instruction_valid(instruction_valid[1]), .instruction_accept(instruction_accept[1]),
        .fetch_error(fetch_error[1]),
        .spi_cs_n(spi_cs_n[1]), .spi_sck(spi_sck[1]), .spi_mosi(spi_mosi[1]), .spi_miso(flash_miso)
    );

    wire bus_cs   = &spi_cs_n;
    wire bus_sck  = |spi_sck;
    wire bus_mosi = |spi_mosi;

    // ---------------- flash model (READ, mode 0) ----------------
    int          fl_bits = 0;
    int          fl_k;
    logic [31:0] fl_sh = '0;
    logic [7:0]  fl_cmd = '0;
    logic [23:0] fl_addr = '0;
    logic [7:0]  fl_byte;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h93;
            24'h000101: return 8'h00;
            24'h000102: return 8'h50;
            24'h000103: return 8'h00;
            24'h000104: return 8'h13;
            24'h000105: return 8'h01;
            24'h000106: return 8'h10;
            24'h000107: return 8'h00;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(negedge bus_cs) fl_bits = 0;

    always @(posedge bus_sck) begin
        if (!bus_cs) begin
            fl_sh = {fl_sh[30:0], bus_mosi};
            fl_bits++;
            if (fl_bits == 32) begin
                fl_cmd  = fl_sh[31:24];
                fl_addr = fl_sh[23:0];
            end
        end
    end

    always @(negedge bus_sck) begin
        if (!bus_cs && fl_bits >= 32 && fl_bits < 64) begin
            fl_k       = fl_bits - 32;
            fl_byte    = flash_byte(fl_addr + 24'(fl_k / 8));
            flash_miso = fl_byte[7 - (fl_k % 8)];
        end
    end

    // ---------------- bus monitor ----------------
    int   cyc = 0, cs_falls = 0, sck_rises = 0, cs_high_run = 0, last_gap = 0;
    int   last_sck_rise = 0, sck_period = 0, mosi_glitch = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !bus_cs) begin
            cs_falls++;
            last_gap = cs_high_run;
        end
        if (bus_cs) cs_high_run++; else cs_high_run = 0;
        if (!prev_sck && bus_sck) begin
            sck_rises++;
            sck_period    = cyc - last_sck_rise;
            last_sck_rise = cyc;
        end
        if (prev_sck && bus_sck && bus_mosi !== prev_mosi) mosi_glitch++;
        prev_cs   = bus_cs;
        prev_sck  = bus_sck;
        prev_mosi = bus_mosi;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          lat;
        logic [23:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_cs_n"},  {31'd0, spi_cs_n[d]}, 32'd1);
        check({tag, "_sck"},   {31'd0, spi_sck[d]}, 32'd0);
        check({tag, "_mosi"},  {31'd0, spi_mosi[d]}, 32'd0);
        check({tag, "_instr"}, instruction[d], 32'd0);
        check({tag, "_valid"}, {31'd0, instruction_valid[d]}, 32'd0);
        check({tag, "_err"},   {31'd0, fetch_error[d]}, 32'd0);
        check({tag, "_ready"}, {31'd0, fetch_ready[d]}, 32'd1);
    endtask

    // Wait (bounded) for fetch_ready, then present one request cycle.
    task automatic issue(input int d, input logic [31:0] addr);
        int guard = 0;
        while (fetch_ready[d] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_request", {31'd0, fetch_ready[d]}, 32'd1);
        fetch_request[d] = 1'b1;
        fetch_address    = addr;
        @(posedge clk);
        #1;
        fetch_request[d] = 1'b0;
        fetch_address    = 32'hDEAD_BEEC;   // later changes must not matter
    endtask

    task automatic run_fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_instr,
                             input logic exp_err, input int exp_lat, input logic [23:0] exp_addr);
        exp_t e;
        int   lat = 0;
        int   falls0, rises0;
        e.instr = exp_instr;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.addr  = exp_addr;
        sb.push_back(e);
        fl_cmd  = 8'hFF;
        fl_addr = 24'h5A5A5A;
        falls0  = cs_falls;
        rises0  = sck_rises;
        issue(d, addr);
        while (instruction_valid[d] !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check("valid", {31'd0, instruction_valid[d]}, 32'd1);
        check("latency", lat, e.lat);
        check("instruction", instruction[d], e.instr);
        check("fetch_error", {31'd0, fetch_error[d]}, {31'd0, e.err});
        check("cs_fall_count", cs_falls - falls0, e.err ? 0 : 1);
        check("sck_rise_count", sck_rises - rises0, e.err ? 0 : 64);
        if (!e.err) begin
            check("command_sent", {24'd0, fl_cmd}, 32'h03);
            check("address_sent", {8'd0, fl_addr}, {8'd0, e.addr});
        end
        n_txn++;
        $display("txn %0d dut%0d addr=0x%08h instr=0x%08h err=%0b latency=%0d",
                 n_txn, d, addr, instruction[d], fetch_error[d], lat);
    endtask

    task automatic do_accept(input int d);
        instruction_accept[d] = 1'b1;
        @(posedge clk);
        #1;
        instruction_accept[d] = 1'b0;
        check("valid_after_accept", {31'd0, instruction_valid[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int falls0, n;

        // Reset values while reset is asserted, and after it is released.
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(0, "post_reset");

        // Basic aligned fetch.
        run_fetch(0, 32'h0000_0100, 32'h0050_0093, 1'b0, 256, 24'h000100);
        check("sck_period_div2", sck_period, 4);

        // Backpressure. The result must stay stable, and a request is ignored.
        falls0 = cs_falls;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            fetch_request[0] = (i == 10);
            fetch_address    = 32'h0000_0200;
            check("bp_valid", {31'd0, instruction_valid[0]}, 32'd1);
            check("bp_instruction", instruction[0], 32'h0050_0093);
            check("bp_ready", {31'd0, fetch_ready[0]}, 32'd0);
        end
        fetch_request[0] = 1'b0;
        check("bp_no_spi", cs_falls - falls0, 0);
        @(posedge clk);
        #1;
        do_accept(0);
        n = 0;
        while (fetch_ready[0] !== 1'b1 && n < 4) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_after_accept", {31'd0, fetch_ready[0]}, 32'd1);

        // Misaligned request: an error result with no bus activity.
        run_fetch(0, 32'h0000_0102, 32'h0, 1'b1, 0, 24'h0);
        check("misaligned_cs_high", {31'd0, spi_cs_n[0]}, 32'd1);
        do_accept(0);

        // Back-to-back fetches with accept on the valid cycle.
        run_fetch(0, 32'h0000_0100, 32'h0050_0093, 1'b0, 256, 24'h000100);
        do_accept(0);
        run_fetch(0, 32'h0000_0104, 32'h0010_0113, 1'b0, 256, 24'h000104);
        check("cs_gap_min", {31'd0, last_gap >= 4}, 32'd1);
        do_accept(0);

        // Reset during the address phase aborts the fetch at once.
        issue(0, 32'h0000_0100);
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_idle(0, "mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_fetch(0, 32'h0000_0100, 32'h0050_0093, 1'b0, 256, 24'h000100);
        do_accept(0);

        // Divider of 1. The upper address byte must be dropped.
        run_fetch(1, 32'hAB_FF_FF_FC, 32'h5A5B_5859, 1'b0, 128, 24'hFFFFFC);
        check("sck_period_div1", sck_period, 2);
        do_accept(1);

        check("mosi_stable_while_sck_high", mosi_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
